// File: rtl/axi_dma_pkg.sv
// axi_dma_pkg: definitions shared by the DMA movers.
//   - FSM state encodings for the s2mm writer
//   - status byte bit positions
//   - AXI 4 KiB burst boundary
//   - log2 helper used to derive AxSIZE from the bus width in bytes
package axi_dma_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ADDR   = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_RESP   = 3'd3;
  localparam state_t ST_STATUS = 3'd4;

  localparam int STAT_OK_BIT    = 0;  // every BRESP was OKAY
  localparam int STAT_TLAST_BIT = 1;  // tlast did not line up with the byte count

  localparam int BOUNDARY_4K = 4096;  // an AXI burst may not cross this

  // log2 of a power-of-two byte count, sized for an AxSIZE field.
  function automatic logic [2:0] size_log2(input int bytes);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_s2mm_burst_calc.sv
// axi_s2mm_burst_calc: length in beats of the next write burst.
//   addr_lo      in  12  low bits of the (BYTES-aligned) burst start address
//   beats_left   in  16  beats still to be written for this transfer
//   burst_beats  out 9   min(beats_left, C_AXI_MAX_BURST+1, beats to next 4 KiB line)
module axi_s2mm_burst_calc
  import axi_dma_pkg::*;
#(
  parameter int C_AXI_WIDTH     = 64,
  parameter int C_AXI_MAX_BURST = 255
) (
  input  logic [11:0] addr_lo,
  input  logic [15:0] beats_left,
  output logic [8:0]  burst_beats
);

  localparam int BYTES = C_AXI_WIDTH / 8;
  localparam int LG    = int'(size_log2(BYTES));
  localparam logic [16:0] MAX_BEATS = 17'(C_AXI_MAX_BURST + 1);

  logic [12:0] bytes_to_4k;
  logic [16:0] beats_to_4k;
  logic [16:0] lim;

  // NOTE: every variable written in this block gets a value before any
  // conditional update, so no path leaves it holding state (no latch).
  always_comb begin
    bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
    beats_to_4k = 17'(bytes_to_4k >> LG);
    lim         = {1'b0, beats_left};
    if (MAX_BEATS < lim)   lim = MAX_BEATS;
    if (beats_to_4k < lim) lim = beats_to_4k;
    burst_beats = lim[8:0];
  end

endmodule

// File: rtl/axi_s2mm.sv
// axi_s2mm: stream-to-memory-mapped writer.
// Takes a command (start address + byte count), drains that many bytes from
// s_axis and writes them with AXI4 INCR bursts, then emits one status byte.
//   s_axis_ctl_*  command in: [ADDR-1:0] start address, [ADDR+15:ADDR] bytes
//   m_axis_st_*   status out: bit0 all BRESP OKAY, bit1 tlast mismatch
//   s_axis_*      write data in (passed straight through to W)
//   m_axi_aw*     write address channel
//   m_axi_w*      write data channel
//   m_axi_b*      write response channel
module axi_s2mm
  import axi_dma_pkg::*;
#(
  parameter int C_AXI_WIDTH      = 64,
  parameter int C_AXI_ADDR_WIDTH = 64,
  parameter int C_AXI_MAX_BURST  = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [C_AXI_ADDR_WIDTH+15:0]  s_axis_ctl_tdata,
  input  logic                          s_axis_ctl_tvalid,
  output logic                          s_axis_ctl_tready,
  output logic [7:0]                    m_axis_st_tdata,
  output logic                          m_axis_st_tvalid,
  input  logic                          m_axis_st_tready,
  input  logic [C_AXI_WIDTH-1:0]        s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_WIDTH-1:0]        m_axi_wdata,
  output logic [C_AXI_WIDTH/8-1:0]      m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready
);

  localparam int BYTES = C_AXI_WIDTH / 8;
  localparam int LG    = int'(size_log2(BYTES));
  localparam int AW    = C_AXI_ADDR_WIDTH;

  state_t           state;
  logic [AW-1:0]    addr_q;
  logic [15:0]      beats_left;
  logic [BYTES-1:0] last_strb;
  logic [8:0]       beat_cnt;
  logic [8:0]       outstanding;
  logic             resp_ok;
  logic             tlast_err;
  logic             bus_up;      // low in reset, high from the first edge after it

  logic [8:0]       burst_beats;
  logic [AW-1:0]    cmd_addr;
  logic [15:0]      cmd_count;
  logic [15:0]      cmd_beats;
  logic [LG-1:0]    cmd_rem;
  logic [BYTES-1:0] cmd_strb;
  logic [7:0]       st_bits;
  logic             ctl_hs, aw_hs, w_hs, wlast_hs, b_hs;
  logic             last_burst, final_beat;

  // addr_q and beats_left only move on a wlast handshake, so the burst length
  // stays stable from AW issue through the whole W burst.
  axi_s2mm_burst_calc #(
    .C_AXI_WIDTH     (C_AXI_WIDTH),
    .C_AXI_MAX_BURST (C_AXI_MAX_BURST)
  ) u_burst_calc (
    .addr_lo     (addr_q[11:0]),
    .beats_left  (beats_left),
    .burst_beats (burst_beats)
  );

  // Command decode: beat count rounded up, strobe mask for the tail beat.
  always_comb begin
    cmd_addr  = s_axis_ctl_tdata[AW-1:0];
    cmd_count = s_axis_ctl_tdata[AW+15:AW];
    cmd_beats = 16'((17'(cmd_count) + 17'(BYTES - 1)) >> LG);
    cmd_rem   = cmd_count[LG-1:0];
    cmd_strb  = '0;
    for (int i = 0; i < BYTES; i++) begin
      cmd_strb[i] = (cmd_rem == '0) || (i < int'(cmd_rem));
    end
  end

  assign last_burst = ({7'd0, burst_beats} == beats_left);

  assign s_axis_ctl_tready = bus_up && (state == ST_IDLE);
  assign m_axi_bready      = bus_up;

  assign m_axi_awvalid = (state == ST_ADDR);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = (state == ST_ADDR) ? 8'(burst_beats - 9'd1) : 8'd0;
  assign m_axi_awsize  = 3'(LG);

  // W channel is a combinational pass-through of the stream.
  assign m_axi_wlast   = (state == ST_DATA) && (beat_cnt == burst_beats - 9'd1);
  assign final_beat    = m_axi_wlast && last_burst;
  assign m_axi_wvalid  = (state == ST_DATA) && s_axis_tvalid;
  assign s_axis_tready = (state == ST_DATA) && m_axi_wready;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = final_beat ? last_strb : '1;

  always_comb begin
    st_bits                 = '0;
    st_bits[STAT_OK_BIT]    = resp_ok;
    st_bits[STAT_TLAST_BIT] = tlast_err;
  end

  assign m_axis_st_tvalid = (state == ST_STATUS);
  assign m_axis_st_tdata  = (state == ST_STATUS) ? st_bits : 8'd0;

  assign ctl_hs   = s_axis_ctl_tvalid && s_axis_ctl_tready;
  assign aw_hs    = m_axi_awvalid && m_axi_awready;
  assign w_hs     = m_axi_wvalid && m_axi_wready;
  assign wlast_hs = w_hs && m_axi_wlast;
  assign b_hs     = m_axi_bvalid && m_axi_bready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      beats_left  <= '0;
      last_strb   <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
      resp_ok     <= 1'b0;
      tlast_err   <= 1'b0;
      bus_up      <= 1'b0;
    end else begin
      bus_up <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (ctl_hs) begin
            addr_q     <= cmd_addr;
            beats_left <= cmd_beats;
            last_strb  <= cmd_strb;
            beat_cnt   <= '0;
            resp_ok    <= 1'b1;
            tlast_err  <= 1'b0;
            state      <= (cmd_count == 16'd0) ? ST_STATUS : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (aw_hs) state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_hs) begin
            // The byte count governs length; tlast is only cross-checked.
            if (s_axis_tlast != final_beat) tlast_err <= 1'b1;
            if (m_axi_wlast) begin
              addr_q     <= addr_q + (AW'(burst_beats) << LG);
              beats_left <= beats_left - {7'd0, burst_beats};
              beat_cnt   <= '0;
              state      <= last_burst ? ST_RESP : ST_ADDR;
            end else begin
              beat_cnt <= beat_cnt + 9'd1;
            end
          end
        end
        ST_RESP: begin
          if (outstanding == 9'd0) state <= ST_STATUS;
        end
        ST_STATUS: begin
          if (m_axis_st_tready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (b_hs && (m_axi_bresp != 2'b00)) resp_ok <= 1'b0;

      // A burst closing and a response arriving in one cycle cancel out.
      case ({wlast_hs, b_hs})
        2'b10:   outstanding <= outstanding + 9'd1;
        2'b01:   outstanding <= outstanding - 9'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_s2mm.sv
// tb_axi_s2mm: randomized bench for axi_s2mm with a scoreboard.
// A transfer-level model splits each command into bursts and beats; expected
// AW, W and status items are queued, and a monitor compares them as the DUT
// hands them out. The AXI slave and stream source use random ready/valid.
`timescale 1ns/1ps
module tb_axi_s2mm;

  localparam int W     = 64;
  localparam int AW    = 64;
  localparam int BYTES = W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW+15:0]    s_axis_ctl_tdata;
  logic              s_axis_ctl_tvalid;
  logic              s_axis_ctl_tready;
  logic [7:0]        m_axis_st_tdata;
  logic              m_axis_st_tvalid;
  logic              m_axis_st_tready;
  logic [W-1:0]      s_axis_tdata;
  logic              s_axis_tlast;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [AW-1:0]     m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [W-1:0]      m_axi_wdata;
  logic [BYTES-1:0]  m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;

  always #5 clk = ~clk;

  axi_s2mm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_ctl_tdata  (s_axis_ctl_tdata),
    .s_axis_ctl_tvalid (s_axis_ctl_tvalid),
    .s_axis_ctl_tready (s_axis_ctl_tready),
    .m_axis_st_tdata   (m_axis_st_tdata),
    .m_axis_st_tvalid  (m_axis_st_tvalid),
    .m_axis_st_tready  (m_axis_st_tready),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .m_axi_awaddr      (m_axi_awaddr),
    .m_axi_awlen       (m_axi_awlen),
    .m_axi_awsize      (m_axi_awsize),
    .m_axi_awvalid     (m_axi_awvalid),
    .m_axi_awready     (m_axi_awready),
    .m_axi_wdata       (m_axi_wdata),
    .m_axi_wstrb       (m_axi_wstrb),
    .m_axi_wlast       (m_axi_wlast),
    .m_axi_wvalid      (m_axi_wvalid),
    .m_axi_wready      (m_axi_wready),
    .m_axi_bresp       (m_axi_bresp),
    .m_axi_bvalid      (m_axi_bvalid),
    .m_axi_bready      (m_axi_bready)
  );

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [W-1:0] data; logic [BYTES-1:0] strb; logic last; } w_t;
  typedef struct { logic [W-1:0] data; logic last; } s_t;

  aw_t        exp_aw[$];
  w_t         exp_w[$];
  logic [7:0] exp_st[$];
  s_t         src_q[$];
  logic [1:0] bresp_plan[$];
  logic [1:0] pending_b[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit stall_w  = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flush_all();
    exp_aw.delete(); exp_w.delete(); exp_st.delete();
    src_q.delete(); bresp_plan.delete(); pending_b.delete();
  endtask

  // Transfer-level model: bursts are cut at 256 beats and at 4 KiB lines;
  // the tail beat's strobe covers count mod 8 bytes.
  task automatic issue_cmd(input logic [AW-1:0] addr, input int count,
                           input int tlast_mode, input int tlast_pos, input int err_burst);
    logic [AW-1:0]    a;
    logic [BYTES-1:0] fstrb;
    int left, total, beat_idx, nb, to4k, n;
    bit ok, mism, fin, got;
    s_t s;
    w_t wb;
    a = addr; total = (count + BYTES - 1) / BYTES; left = total;
    beat_idx = 0; nb = 0; ok = 1'b1; mism = 1'b0;
    fstrb = (count % BYTES == 0) ? 8'hFF : 8'(8'hFF >> (BYTES - count % BYTES));
    while (left > 0) begin
      to4k = (4096 - int'(a % 4096)) / BYTES;
      n = left;
      if (n > 256) n = 256;
      if (to4k < n) n = to4k;
      exp_aw.push_back('{addr: a, len: 8'(n - 1)});
      bresp_plan.push_back((nb == err_burst) ? 2'b10 : 2'b00);
      if (nb == err_burst) ok = 1'b0;
      for (int j = 0; j < n; j++) begin
        fin = (beat_idx == total - 1);
        s.data = {$urandom, $urandom};
        case (tlast_mode)
          0:       s.last = fin;
          1:       s.last = (beat_idx == tlast_pos);
          default: s.last = 1'b0;
        endcase
        if (s.last != fin) mism = 1'b1;
        wb.data = s.data;
        wb.strb = fin ? fstrb : 8'hFF;
        wb.last = (j == n - 1);
        src_q.push_back(s);
        exp_w.push_back(wb);
        beat_idx++;
      end
      a = a + AW'(n * BYTES);
      left -= n;
      nb++;
    end
    exp_st.push_back({6'd0, mism, ok});

    @(negedge clk);
    s_axis_ctl_tdata  = {16'(count), addr};
    s_axis_ctl_tvalid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      #4;
      if (s_axis_ctl_tready) got = 1'b1;
      @(negedge clk);
    end
    s_axis_ctl_tvalid = 1'b0;
    check("ctl_accept", got, 1);
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (exp_st.size() != 0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check("status_seen", exp_st.size() == 0, 1);
    check("aw_drained", exp_aw.size(), 0);
    check("w_drained", exp_w.size(), 0);
    if (exp_st.size() != 0) flush_all();
  endtask

  task automatic run(input logic [AW-1:0] addr, input int count,
                     input int tlast_mode, input int tlast_pos, input int err_burst);
    issue_cmd(addr, count, tlast_mode, tlast_pos, err_burst);
    wait_done();
  endtask

  // Slave/source driver on the falling edge, monitor one ns before rising.
  initial begin : bus_model
    bit s_done, b_done;
    s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tlast = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axis_st_tready = 0;
    s_done = 0; b_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_axis_tvalid = 0; s_axis_tlast = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axis_st_tready = 0;
        s_done = 0; b_done = 0;
      end else begin
        if (s_done) s_axis_tvalid = 1'b0;
        if (b_done) m_axi_bvalid = 1'b0;
        s_done = 0; b_done = 0;
        if (!s_axis_tvalid && src_q.size() > 0 && $urandom_range(3) != 0) s_axis_tvalid = 1'b1;
        if (s_axis_tvalid) begin
          s_axis_tdata = src_q[0].data;
          s_axis_tlast = src_q[0].last;
        end
        m_axi_awready    = ($urandom_range(3) != 0);
        m_axi_wready     = !stall_w && ($urandom_range(3) != 0);
        m_axis_st_tready = ($urandom_range(3) != 0);
        if (!m_axi_bvalid && pending_b.size() > 0 && $urandom_range(1) == 1) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = pending_b[0];
        end
        #4;
        if (rst_n) begin
          if (m_axi_awvalid && m_axi_awready) begin
            check("aw_expected", exp_aw.size() > 0, 1);
            if (exp_aw.size() > 0) begin
              check("awaddr", m_axi_awaddr, exp_aw[0].addr);
              check("awlen", m_axi_awlen, exp_aw[0].len);
              check("awsize", m_axi_awsize, 3);
              void'(exp_aw.pop_front());
            end
          end
          if ((m_axi_wvalid && m_axi_wready) || (s_axis_tvalid && s_axis_tready))
            check("w_s_handshake_sync", m_axi_wvalid && m_axi_wready, s_axis_tvalid && s_axis_tready);
          if (m_axi_wvalid && m_axi_wready) begin
            check("w_expected", exp_w.size() > 0, 1);
            if (exp_w.size() > 0) begin
              check("wdata", m_axi_wdata, exp_w[0].data);
              check("wstrb", m_axi_wstrb, exp_w[0].strb);
              check("wlast", m_axi_wlast, exp_w[0].last);
              void'(exp_w.pop_front());
            end
            if (m_axi_wlast && bresp_plan.size() > 0) pending_b.push_back(bresp_plan.pop_front());
          end
          if (s_axis_tvalid && s_axis_tready) begin
            if (src_q.size() > 0) void'(src_q.pop_front());
            s_done = 1;
          end
          if (m_axi_bvalid && m_axi_bready) begin
            if (pending_b.size() > 0) void'(pending_b.pop_front());
            b_done = 1;
          end
          if (m_axis_st_tvalid && m_axis_st_tready) begin
            check("status_expected", exp_st.size() > 0, 1);
            if (exp_st.size() > 0) begin
              check("status", m_axis_st_tdata, exp_st[0]);
              void'(exp_st.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin : main
    logic [AW-1:0] addr;
    int count, mode, pos, err;
    bit seen;
    s_axis_ctl_tvalid = 0;
    s_axis_ctl_tdata  = '0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    #4;
    check("rst_ctl_tready", s_axis_ctl_tready, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_st_tvalid", m_axis_st_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_st_tdata", m_axis_st_tdata, 0);
    check("rst_awaddr", m_axi_awaddr, 0);
    check("rst_awlen", m_axi_awlen, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("ctl_tready_before_edge", s_axis_ctl_tready, 0);
    @(negedge clk);
    check("ctl_tready_after_edge", s_axis_ctl_tready, 1);
    check("bready_after_edge", m_axi_bready, 1);

    run(64'h1000, 64, 0, 0, -1);    // one 8-beat burst
    run(64'h2000, 13, 0, 0, -1);    // 2 beats, tail strobe 0x1F
    run(64'h0FF0, 64, 0, 0, -1);    // split at the 4 KiB line
    run(64'h0000, 4096, 0, 0, 1);   // two 256-beat bursts, second SLVERR
    run(64'h5000, 24, 1, 0, -1);    // early tlast: status 0x03
    run(64'h6000, 0, 0, 0, -1);     // empty transfer

    // Reset while a W beat is stalled by the slave.
    stall_w = 1'b1;
    issue_cmd(64'h3000, 64, 0, 0, -1);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      #4;
      if (m_axi_wvalid) seen = 1'b1;
    end
    check("wvalid_before_reset", seen, 1);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_awvalid", m_axi_awvalid, 0);
    check("mid_rst_wvalid", m_axi_wvalid, 0);
    check("mid_rst_s_tready", s_axis_tready, 0);
    check("mid_rst_ctl_tready", s_axis_ctl_tready, 0);
    check("mid_rst_bready", m_axi_bready, 0);
    check("mid_rst_st_tvalid", m_axis_st_tvalid, 0);
    check("mid_rst_awaddr", m_axi_awaddr, 0);
    flush_all();
    repeat (2) @(negedge clk);
    stall_w = 1'b0;
    rst_n = 1;
    run(64'h3000, 64, 0, 0, -1);

    for (int k = 0; k < 20; k++) begin
      addr  = 64'($urandom_range(0, 16383)) * 64'd8;
      count = $urandom_range(0, 1600);
      mode  = $urandom_range(0, 2);
      pos   = $urandom_range(0, count / BYTES);
      err   = ($urandom_range(0, 7) > 5) ? $urandom_range(0, 3) : -1;
      run(addr, count, mode, pos, err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_s2mm.md
# axi_s2mm

Stream-to-memory-mapped writer: accepts a command (start address + byte count) on a control stream, drains that many bytes from an AXI-Stream data input, and writes them to memory through an AXI4 write master in INCR bursts. It is the write-direction counterpart of the mm2s reader and sits between packet-producing cores and the DMA/DDR interconnect. When the transfer completes it emits one status byte. AWBURST, AWPROT, AWCACHE and AWUSER are constants driven by the integration wrapper, not by this block.

## Interface
- C_AXI_WIDTH, 64: data width in bits (power of two, ≥32); BYTES = C_AXI_WIDTH/8.
- C_AXI_ADDR_WIDTH, 64: address width.
- C_AXI_MAX_BURST, 255: largest AWLEN value issued (bursts ≤ C_AXI_MAX_BURST+1 beats).
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_ctl_tdata  in  C_AXI_ADDR_WIDTH+16  [ADDR-1:0] start address (BYTES-aligned), [ADDR+15:ADDR] byte count.
- s_axis_ctl_tvalid / s_axis_ctl_tready  in / out  1  command handshake.
- m_axis_st_tdata  out  8  status: bit0 = all BRESP OKAY, bit1 = tlast mismatch, bits 7:2 = 0.
- m_axis_st_tvalid / m_axis_st_tready  out / in  1  status handshake.
- s_axis_tdata  in  C_AXI_WIDTH  write data; s_axis_tlast in 1; s_axis_tvalid in 1; s_axis_tready out 1.
- m_axi_awaddr  out  C_AXI_ADDR_WIDTH; m_axi_awlen out 8; m_axi_awsize out 3; m_axi_awvalid out 1; m_axi_awready in 1.
- m_axi_wdata out C_AXI_WIDTH; m_axi_wstrb out BYTES; m_axi_wlast out 1; m_axi_wvalid out 1; m_axi_wready in 1.
- m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1.

## Operation
- States: IDLE → ADDR → DATA → (ADDR | RESP) → STATUS → IDLE.
- IDLE: ctl_tready=1. On handshake latch addr, beats_left = ceil(count/BYTES), last_strb = (count mod BYTES == 0) ? all-ones : (1<<(count mod BYTES))−1; clear error flags. count==0 → STATUS directly.
- ADDR: burst_beats = min(beats_left, C_AXI_MAX_BURST+1, beats to next 4 KiB boundary); awlen = burst_beats−1; awsize = log2(BYTES); hold awvalid until awready; then DATA.
- DATA: wvalid = s_axis_tvalid, s_axis_tready = wready, wdata = s_axis_tdata (combinational pass-through); wlast on final beat of burst; wstrb all-ones except final beat of transfer = last_strb. After wlast handshake: addr += burst_beats*BYTES; beats_left −= burst_beats; outstanding++; → ADDR if beats_left>0 else RESP.
- tlast mismatch (bit1 set): s_axis_tlast=1 on any beat except the transfer's final beat, or 0 on the final beat. Transfer length is always governed by the byte count.
- bready=1 in all states except reset; each B handshake decrements outstanding; BRESP≠OKAY clears bit0. Simultaneous wlast and B handshake: counter net unchanged.
- RESP: wait outstanding==0 → STATUS. STATUS: st_tvalid held until st_tready, then IDLE.

## Timing
- Reset values: all *valid outputs 0, s_axis_tready 0, ctl_tready 0, bready 0, st_tdata 0, awaddr/awlen 0, counters 0, state IDLE. ctl_tready and bready rise at first clock edge after rst_n deasserts.
- ctl accept → awvalid asserted next cycle. AW handshake → DATA next cycle. wlast handshake → next awvalid next cycle.
- W path zero-latency; no buffering, so AW is never issued for data not yet requested but W may stall on s_axis.
- Last B handshake → st_tvalid two cycles later (RESP, STATUS). count==0 → st_tvalid cycle after accept.
- Reset mid-operation: everything returns to reset values immediately; in-flight AXI transactions abandoned (interconnect shares reset).
- Outstanding counter 9 bits; address arithmetic modulo 2^C_AXI_ADDR_WIDTH.

## Structure
- Shared package axi_dma_pkg: state enum, status bit indices, 4 KiB boundary constant, log2 helper for awsize.
- One sub-module, axi_s2mm_burst_calc: combinational burst_beats from addr, beats_left, C_AXI_MAX_BURST.

## Test plan
- addr 0x1000, count 64 → one AW awaddr 0x1000 awlen 7 awsize 3; 8 beats, wlast on 8th, wstrb 0xFF; B OKAY, tlast on beat 8 → status 0x01.
- addr 0x2000, count 13 → awlen 1; beat 2 wstrb 0x1F; status 0x01.
- addr 0x0FF0, count 64 → AW 0x0FF0 awlen 1, then AW 0x1000 awlen 5; 8 W beats total.
- addr 0x0, count 4096 → AW 0x0 awlen 255, AW 0x800 awlen 255; second BRESP SLVERR → status 0x00.
- count 24, tlast on beat 1 → 3 beats still written, status 0x03; count 0 → no AW/W, status 0x01.
- rst_n low mid-DATA with backpressured wready → all valids 0 immediately; next command after reset completes normally.
